// File: rtl/debounce_scheduler_if.sv
// Signal bundle between the debounce scheduler and its environment.
// The master drives the raw inputs and enable; the slave (the scheduler) returns debounced levels and status.
interface debounce_scheduler_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              enable;
  logic [NUM_CH-1:0] sig_i;
  logic [NUM_CH-1:0] sig_o;
  logic [NUM_CH-1:0] rise_o;
  logic [NUM_CH-1:0] fall_o;
  logic              busy;
  logic [CH_W-1:0]   active_ch;

  modport master (
    output enable, sig_i,
    input  sig_o, rise_o, fall_o, busy, active_ch
  );

  modport slave (
    input  enable, sig_i,
    output sig_o, rise_o, fall_o, busy, active_ch
  );
endinterface

// File: rtl/debounce_scheduler.sv
// Multi-channel debouncer sharing one stability timer, granted round-robin to mismatching channels.
// Optional macro DEBOUNCE_EVENT_EN enables the registered rise_o/fall_o edge pulses.
module debounce_scheduler #(
  parameter int NUM_CH            = 4,
  parameter int CLK_PERIOD_ns     = 20,
  parameter int DEBOUNCE_TIMER_ns = 30_000_000
) (
  input  logic                clk,
  input  logic                resetn,
  debounce_scheduler_if.slave bus
);

  localparam int CH_W      = $clog2(NUM_CH);
  localparam int SUM_W     = CH_W + 1;
  localparam int TICKS_RAW = (DEBOUNCE_TIMER_ns - 2 * CLK_PERIOD_ns) / CLK_PERIOD_ns;
  localparam int TICKS     = (TICKS_RAW < 1) ? 1 : TICKS_RAW;
  localparam int CNT_W     = $clog2(TICKS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TIMING = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] meta_r;
  logic [NUM_CH-1:0] sync_r;
  logic [1:0]        state_r;
  logic [1:0]        state_n;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_n;
  logic [CH_W-1:0]   active_ch_r;
  logic [CH_W-1:0]   active_ch_n;
  logic [CH_W-1:0]   ptr_r;
  logic [CH_W-1:0]   ptr_n;
  logic              target_r;
  logic              target_n;
  logic [NUM_CH-1:0] sig_r;
  logic [NUM_CH-1:0] sig_n;
  logic              busy_r;
  logic [NUM_CH-1:0] mismatch_s;
  logic              grant_valid_s;
  logic [CH_W-1:0]   grant_ch_s;

  // Two-flop synchronisers; they keep sampling even while frozen
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= bus.sig_i;
      sync_r <= meta_r;
    end
  end

  assign mismatch_s = sync_r ^ sig_r;

  // Round-robin pick: first mismatching channel strictly after the last grant, wrapping
  always_comb begin : pick_c
    logic [SUM_W-1:0] sum_v;
    logic [SUM_W-1:0] wrap_v;
    logic [CH_W-1:0]  cand_v;
    logic             hit_v;
    sum_v         = '0;
    wrap_v        = '0;
    cand_v        = '0;
    hit_v         = 1'b0;
    grant_valid_s = 1'b0;
    grant_ch_s    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      sum_v         = {1'b0, ptr_r} + SUM_W'(k);
      wrap_v        = (sum_v >= SUM_W'(NUM_CH)) ? (sum_v - SUM_W'(NUM_CH)) : sum_v;
      cand_v        = CH_W'(wrap_v);
      hit_v         = mismatch_s[cand_v] & ~grant_valid_s;
      grant_ch_s    = hit_v ? cand_v : grant_ch_s;
      grant_valid_s = grant_valid_s | hit_v;
    end
  end

  // Scheduler next-state; every update is gated by enable
  always_comb begin
    state_n     = state_r;
    count_n     = count_r;
    active_ch_n = active_ch_r;
    ptr_n       = ptr_r;
    target_n    = target_r;
    sig_n       = sig_r;
    if (bus.enable) begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            active_ch_n = grant_ch_s;
            target_n    = sync_r[grant_ch_s];
            count_n     = '0;
            state_n     = TIMING;
          end else begin
            state_n     = IDLE;
          end
        end
        TIMING: begin
          if (sync_r[active_ch_r] != target_r) begin
            // Bounce: give up this channel and let the next one in line have the timer
            ptr_n   = active_ch_r;
            state_n = IDLE;
          end else if (count_r == LAST_CNT) begin
            state_n = COMMIT;
          end else begin
            count_n = count_r + CNT_ONE;
          end
        end
        COMMIT: begin
          sig_n[active_ch_r] = target_r;
          ptr_n              = active_ch_r;
          state_n            = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Scheduler state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      count_r     <= '0;
      active_ch_r <= '0;
      ptr_r       <= LAST_CH;
      target_r    <= 1'b0;
      sig_r       <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      count_r     <= count_n;
      active_ch_r <= active_ch_n;
      ptr_r       <= ptr_n;
      target_r    <= target_n;
      sig_r       <= sig_n;
      busy_r      <= (state_n != IDLE);
    end
  end

  assign bus.sig_o     = sig_r;
  assign bus.busy      = busy_r;
  assign bus.active_ch = active_ch_r;

`ifdef DEBOUNCE_EVENT_EN
  logic [NUM_CH-1:0] rise_r;
  logic [NUM_CH-1:0] fall_r;

  // One-cycle edge pulse on the enabled commit cycle only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      rise_r <= '0;
      fall_r <= '0;
      if (bus.enable && (state_r == COMMIT)) begin
        rise_r[active_ch_r] <= target_r;
        fall_r[active_ch_r] <= ~target_r;
      end
    end
  end

  assign bus.rise_o = rise_r;
  assign bus.fall_o = fall_r;
`else
  assign bus.rise_o = '0;
  assign bus.fall_o = '0;
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler (NUM_CH=4, 20 ns clock, 200 ns debounce -> 8 ticks).
// Table vectors, hand-written corner sequences, and random stimulus against a timestamp-style model.
module tb_debounce_scheduler;
  localparam int NUM_CH = 4;
  localparam int TICKS  = 8;
`ifdef DEBOUNCE_EVENT_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  int   tests_run    = 0;
  int   tests_failed = 0;

  debounce_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  debounce_scheduler #(
    .NUM_CH(NUM_CH),
    .CLK_PERIOD_ns(20),
    .DEBOUNCE_TIMER_ns(200)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] sig;
    int         hold;
    logic [3:0] exp_o;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
    logic       exp_busy;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ev(input logic [3:0] v);
    return EV_EN ? v : 4'b0000;
  endfunction

  task automatic do_reset();
    resetn     = 1'b0;
    bus.enable = 1'b1;
    bus.sig_i  = 4'b0000;
    repeat (2) step();
    resetn = 1'b1;
  endtask

  task automatic add(input logic rst, input logic en, input logic [3:0] sig, input int hold,
                     input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef,
                     input logic eb, input logic [1:0] ec);
    vec_t v;
    v.rst = rst; v.en = en; v.sig = sig; v.hold = hold;
    v.exp_o = eo; v.exp_rise = ev(er); v.exp_fall = ev(ef); v.exp_busy = eb; v.exp_ch = ec;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eo, input logic [3:0] er,
                            input logic [3:0] ef, input logic eb, input logic [1:0] ec);
    check({tag, ".sig_o"}, 32'(bus.sig_o), 32'(eo));
    check({tag, ".rise_o"}, 32'(bus.rise_o), 32'(er));
    check({tag, ".fall_o"}, 32'(bus.fall_o), 32'(ef));
    check({tag, ".busy"}, 32'(bus.busy), 32'(eb));
    if (eb) check({tag, ".active_ch"}, 32'(bus.active_ch), 32'(ec));
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      bus.enable = vecs[i].en;
      bus.sig_i  = vecs[i].sig;
      repeat (vecs[i].hold) step();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_rise, vecs[i].exp_fall,
                 vecs[i].exp_busy, vecs[i].exp_ch);
    end
  endtask

  task automatic seq_bounce();
    logic [3:0] pulses;
    pulses = 4'b0000;
    do_reset();
    bus.sig_i = 4'b0100;
    repeat (5) begin step(); pulses |= bus.rise_o | bus.fall_o; end
    bus.sig_i = 4'b0000;
    repeat (2) begin step(); pulses |= bus.rise_o | bus.fall_o; end
    check("bounce.busy_timing", 32'(bus.busy), 32'd1);
    check("bounce.ch_timing", 32'(bus.active_ch), 32'd2);
    step();
    check("bounce.abort_busy", 32'(bus.busy), 32'd0);
    check("bounce.abort_sig_o", 32'(bus.sig_o), 32'd0);
    bus.sig_i = 4'b0100;
    repeat (11) begin step(); pulses |= bus.rise_o | bus.fall_o; end
    check("bounce.no_pulse", 32'(pulses), 32'd0);
    check("bounce.pre_commit", 32'(bus.sig_o), 32'd0);
    step();
    check("bounce.commit", 32'(bus.sig_o), 32'(4'b0100));
    check("bounce.rise", 32'(bus.rise_o), 32'(ev(4'b0100)));
  endtask

  task automatic seq_freeze();
    logic frozen_ok;
    frozen_ok = 1'b1;
    do_reset();
    bus.sig_i = 4'b0010;
    repeat (6) step();
    check("freeze.busy", 32'(bus.busy), 32'd1);
    check("freeze.ch", 32'(bus.active_ch), 32'd1);
    bus.enable = 1'b0;
    repeat (20) begin
      step();
      if (bus.busy !== 1'b1 || bus.active_ch !== 2'd1 || bus.rise_o !== 4'b0000 ||
          bus.fall_o !== 4'b0000 || bus.sig_o !== 4'b0000) frozen_ok = 1'b0;
    end
    check("freeze.held", 32'(frozen_ok), 32'd1);
    bus.enable = 1'b1;
    repeat (5) step();
    check("freeze.slip_pre", 32'(bus.sig_o), 32'd0);
    check("freeze.slip_busy", 32'(bus.busy), 32'd1);
    step();
    check("freeze.commit", 32'(bus.sig_o), 32'(4'b0010));
    check("freeze.rise", 32'(bus.rise_o), 32'(ev(4'b0010)));
  endtask

  task automatic seq_reset();
    do_reset();
    bus.sig_i = 4'b1000;
    repeat (6) step();
    check("rst.busy_before", 32'(bus.busy), 32'd1);
    check("rst.ch_before", 32'(bus.active_ch), 32'd3);
    resetn    = 1'b0;
    bus.sig_i = 4'b1010;
    #1;
    check_outs("rst.async", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    check("rst.ch_zero", 32'(bus.active_ch), 32'd0);
    repeat (2) step();
    resetn = 1'b1;
    repeat (2) step();
    check("rst.idle", 32'(bus.busy), 32'd0);
    step();
    check("rst.regrant_busy", 32'(bus.busy), 32'd1);
    check("rst.regrant_ch", 32'(bus.active_ch), 32'd1);
  endtask

  // Reference: a channel owns the timer from its grant; it commits once it has seen
  // TICKS+1 further enabled edges, aborting if the synchronised level leaves target within the first TICKS.
  task automatic run_random(input int cycles);
    logic [3:0] hist[$];
    logic [3:0] model_o, sig, sync_v, er, ef;
    logic [1:0] fi;
    logic       en, tgt;
    int         owner, last, elapsed;
    model_o = 4'b0000; owner = -1; last = NUM_CH - 1; elapsed = 0; tgt = 1'b0;
    hist.push_back(4'b0000);
    hist.push_back(4'b0000);
    sig = 4'b0000;
    do_reset();
    for (int c = 0; c < cycles && tests_failed < 20; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) begin
        fi = 2'($urandom_range(0, 3));
        sig[fi] = ~sig[fi];
      end
      bus.enable = en;
      bus.sig_i  = sig;
      sync_v = hist[0];
      er = 4'b0000;
      ef = 4'b0000;
      if (en) begin
        if (owner < 0) begin
          for (int k = 1; k <= NUM_CH; k++) begin
            int ch;
            ch = (last + k) % NUM_CH;
            if (owner < 0 && sync_v[ch] != model_o[ch]) begin
              owner = ch; tgt = sync_v[ch]; elapsed = 0;
            end
          end
        end else if (elapsed < TICKS && sync_v[owner] != tgt) begin
          last = owner; owner = -1;
        end else begin
          elapsed++;
          if (elapsed == TICKS + 1) begin
            model_o[owner] = tgt;
            if (tgt) er[owner] = 1'b1;
            else     ef[owner] = 1'b1;
            last = owner; owner = -1;
          end
        end
      end
      void'(hist.pop_front());
      hist.push_back(sig);
      step();
      check_outs($sformatf("rnd%0d", c), model_o, ev(er), ev(ef), (owner >= 0),
                 (owner >= 0) ? 2'(owner) : 2'd0);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    bus.enable = 1'b1;
    bus.sig_i  = 4'b0000;
    #1;
    check_outs("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    check("reset.active_ch", 32'(bus.active_ch), 32'd0);

    // Clean press on ch0, then release
    add(1'b1, 1'b1, 4'b0001, 2,  4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 1'b1, 4'b0001, 1,  4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0);
    add(1'b0, 1'b1, 4'b0001, 8,  4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0);
    add(1'b0, 1'b1, 4'b0001, 1,  4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 1'b1, 4'b0001, 1,  4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 1'b1, 4'b0000, 11, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0);
    add(1'b0, 1'b1, 4'b0000, 1,  4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
    // Contention: 1011 served ch0, ch1, ch3 ten cycles apart
    add(1'b1, 1'b1, 4'b1011, 3,  4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0);
    add(1'b0, 1'b1, 4'b1011, 9,  4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 1'b1, 4'b1011, 1,  4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd1);
    add(1'b0, 1'b1, 4'b1011, 9,  4'b0011, 4'b0010, 4'b0000, 1'b0, 2'd1);
    add(1'b0, 1'b1, 4'b1011, 1,  4'b0011, 4'b0000, 4'b0000, 1'b1, 2'd3);
    add(1'b0, 1'b1, 4'b1011, 9,  4'b1011, 4'b1000, 4'b0000, 1'b0, 2'd3);
    add(1'b0, 1'b1, 4'b1011, 1,  4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 1'b1, 4'b0000, 12, 4'b1010, 4'b0000, 4'b0001, 1'b0, 2'd0);
    run_table();

    seq_bounce();
    seq_freeze();
    seq_reset();
    run_random(4000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
